// File: rtl/cpri_tx_pkg_arbiter_pkg.sv
// Shared types, defaults and round-robin helpers for the CPRI TX packet-buffer arbiter.
package cpri_tx_pkg_arbiter_pkg;

    localparam int TIMEOUT_DEF = 64;
    localparam int AW_DEF      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    // One-hot grant of the first set request at or after ptr, wrapping modulo n (n <= 8).
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] gnt;
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        gnt   = 8'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(n)) begin
                sum = sum - 4'(n);
            end else begin
                sum = sum;
            end
            idx = sum[2:0];
            if ((k < n) && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = idx | (oh[k] ? 3'(k) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cpri_rr_arb.sv
// Round-robin pick with a registered priority pointer; the pointer moves past the
// winner when the owner of the shared resource releases it.
module cpri_rr_arb
    import cpri_tx_pkg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_adv,
    input  logic [NUM_REQ-1:0] i_adv_gnt,
    output logic [NUM_REQ-1:0] o_pick
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic [2:0] won_idx;

    assign o_pick  = NUM_REQ'(rr_pick(8'(i_req), ptr_q, NUM_REQ));
    assign won_idx = oh_to_idx(8'(i_adv_gnt));

    // Next pointer: one past the released winner, wrapping at NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (i_adv) begin
            ptr_d = (won_idx == LAST_IDX) ? 3'd0 : (won_idx + 3'd1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cpri_tx_pkg_arbiter.sv
// Shares one CPRI TX packet-buffer write port among NUM_REQ package builders: grants a
// whole packet at a time, re-addresses and forwards words one cycle late, aborts stalls.
module cpri_tx_pkg_arbiter
    import cpri_tx_pkg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 64,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_vld,
    input  logic [NUM_REQ*DW-1:0] i_data,
    input  logic [NUM_REQ-1:0]    i_last,
    input  logic                  i_buf_rdy,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic                  o_cpri_wen,
    output logic [AW-1:0]         o_cpri_waddr,
    output logic [DW-1:0]         o_cpri_wdata,
    output logic                  o_cpri_wlast,
    output logic                  o_err_timeout,
    output logic                  o_err_ovf,
    output logic [15:0]           o_pkt_cnt
);

    localparam int            SW        = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] IDX_MAX   = {AW{1'b1}};
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
    logic [AW-1:0]      idx_q, idx_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic               wen_q, wen_d, wlast_q, wlast_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               tmo_q, tmo_d, ovf_q, ovf_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;
    logic               adv;
    logic               sel_vld, sel_last;
    logic [DW-1:0]      sel_data;

    cpri_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_adv     (adv),
        .i_adv_gnt (gnt_q),
        .o_pick    (pick)
    );

    // Mux the granted source onto a single word lane.
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = {DW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_vld  = sel_vld  | (i_vld[k]  & gnt_q[k]);
            sel_last = sel_last | (i_last[k] & gnt_q[k]);
            sel_data = sel_data | (i_data[k*DW +: DW] & {DW{gnt_q[k]}});
        end
    end

    // Packet FSM: next state, grant, counters and the registered write-port image.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        stall_d   = stall_q;
        wen_d     = 1'b0;
        waddr_d   = {AW{1'b0}};
        wdata_d   = {DW{1'b0}};
        wlast_d   = 1'b0;
        tmo_d     = 1'b0;
        ovf_d     = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        adv       = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d   = {AW{1'b0}};
                stall_d = {SW{1'b0}};
                if ((|i_req) && i_buf_rdy) begin
                    gnt_d   = pick;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT, XFER: begin
                if (sel_vld) begin
                    wen_d   = 1'b1;
                    waddr_d = idx_q;
                    wdata_d = sel_data;
                    stall_d = {SW{1'b0}};
                    idx_d   = idx_q + 1'b1;
                    if (sel_last) begin
                        wlast_d   = 1'b1;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        gnt_d     = {NUM_REQ{1'b0}};
                        adv       = 1'b1;
                        state_d   = GAP;
                    end else if (idx_q == IDX_MAX) begin
                        wlast_d = 1'b1;
                        ovf_d   = 1'b1;
                        gnt_d   = {NUM_REQ{1'b0}};
                        adv     = 1'b1;
                        state_d = GAP;
                    end else begin
                        state_d = XFER;
                    end
                end else if (stall_q == STALL_MAX) begin
                    // A packet already under way is closed with a zero dummy word.
                    wen_d   = (state_q == XFER);
                    waddr_d = (state_q == XFER) ? idx_q : {AW{1'b0}};
                    wlast_d = (state_q == XFER);
                    tmo_d   = 1'b1;
                    gnt_d   = {NUM_REQ{1'b0}};
                    adv     = 1'b1;
                    state_d = GAP;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                gnt_d   = {NUM_REQ{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= {NUM_REQ{1'b0}};
            idx_q     <= {AW{1'b0}};
            stall_q   <= {SW{1'b0}};
            wen_q     <= 1'b0;
            waddr_q   <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            wlast_q   <= 1'b0;
            tmo_q     <= 1'b0;
            ovf_q     <= 1'b0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            stall_q   <= stall_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wlast_q   <= wlast_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_cpri_wen    = wen_q;
    assign o_cpri_waddr  = waddr_q;
    assign o_cpri_wdata  = wdata_q;
    assign o_cpri_wlast  = wlast_q;
    assign o_err_timeout = tmo_q;
    assign o_err_ovf     = ovf_q;
    assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: doc/cpri_tx_pkg_arbiter.md
Name: cpri_tx_pkg_arbiter

Overview:
- Round-robin scheduler that shares one CPRI TX packet buffer write port (wen/waddr/wdata/wlast) between NUM_REQ package-builder sources, for example several antenna-group lanes feeding one cpri_tx_gen.
- A source requests when a complete packet is staged. The arbiter grants one source at a time and holds the grant until that packet's last word.
- It regenerates the buffer address, forwards the words one cycle late, and recovers from stalled or over-long sources.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- DW, 64, data word width.
- AW, 7, buffer address width; a packet is at most 2**AW words.
- TIMEOUT, 64, maximum cycles from grant to first word, and maximum gap between words, before abort.

Ports:
- clk  in  1  system clock, 491.52 MHz domain.
- rst_n  in  1  synchronous active-low reset.
- i_req  in  NUM_REQ  per-source request: a full packet is staged.
- i_vld  in  NUM_REQ  per-source word valid.
- i_data  in  NUM_REQ*DW  per-source data; source n occupies bits [n*DW +: DW].
- i_last  in  NUM_REQ  per-source last-word flag.
- i_buf_rdy  in  1  downstream buffer can accept a new packet; sampled only when a grant is issued.
- o_gnt  out  NUM_REQ  one-hot grant.
- o_cpri_wen  out  1  buffer write enable.
- o_cpri_waddr  out  AW  buffer write address.
- o_cpri_wdata  out  DW  buffer write data.
- o_cpri_wlast  out  1  last word of the packet.
- o_err_timeout  out  1  one-cycle pulse when a packet is aborted for a stall.
- o_err_ovf  out  1  one-cycle pulse when a packet is truncated for exceeding 2**AW words.
- o_pkt_cnt  out  16  count of completed packets, wraps at 65535.

Behaviour:
- Reset:
  - All outputs are 0.
  - The state machine goes to IDLE.
  - The round-robin pointer is 0, so source 0 has highest priority first.
  - Reset mid-packet drops the packet immediately; no wlast is emitted.
- State machine IDLE -> GRANT -> XFER -> GAP -> IDLE.
- IDLE:
  - Leaves only when i_req is non-zero and i_buf_rdy=1.
  - Picks the first requesting source at or after the pointer, searching upward modulo NUM_REQ.
  - Asserts o_gnt in the next cycle and enters GRANT.
- GRANT:
  - Waits for i_vld of the granted source and clears the stall counter.
  - The first valid word moves the state to XFER.
  - Stall counter reaching TIMEOUT -> o_err_timeout pulse, grant dropped, go to GAP, nothing written.
- XFER:
  - Each valid word from the granted source is forwarded on the next cycle: o_cpri_wen=1, o_cpri_wdata=that word, o_cpri_waddr=word index.
  - The word index starts at 0 and increments per valid word.
  - Inputs from non-granted sources are ignored.
  - i_last from the granted source -> o_cpri_wlast=1 with that word, o_pkt_cnt+1, go to GAP.
  - Word index reaching 2**AW-1 without i_last -> that word is written with o_cpri_wlast forced to 1, o_err_ovf pulses, go to GAP.
  - Gap between valid words reaching TIMEOUT -> one dummy write at the next address with wdata=0 and wlast=1, o_err_timeout pulses, go to GAP. o_pkt_cnt is not incremented.
- GAP:
  - o_gnt=0 for exactly one cycle.
  - The pointer moves to the granted index + 1, modulo NUM_REQ.
  - Then return to IDLE.
- Timing:
  - Minimum spacing between back-to-back packets is 2 idle cycles: GAP plus the IDLE decision.
  - Latency from an input word to its output write is 1 cycle, from a registered output.
- Grant and request interaction:
  - o_gnt stays stable for the whole packet; a request dropping mid-packet does not end the grant.
  - A request on the same cycle as another source's last word waits for IDLE.
- i_buf_rdy falling during XFER has no effect; the packet completes.

Decomposition:
- Package cpri_tx_pkg_arbiter_pkg:
  - state enum: IDLE, GRANT, XFER, GAP.
  - TIMEOUT and AW defaults.
  - function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module is natural: cpri_rr_arb. It is the combinational round-robin pick plus the registered pointer, and is reusable for other shared-resource arbitration in the lane.
- The FSM, counters and output register stay in the top module.

Test Plan:
- NUM_REQ=4, req=4'b0001, i_buf_rdy=1, source 0 sends 60 words with last on word 59:
  - o_gnt=0001.
  - 60 writes at addresses 0..59, each one cycle after its input word.
  - wlast on address 59; o_pkt_cnt=1.
- req=4'b1111 held, every source sends 10-word packets:
  - Grant order 0,1,2,3,0,...
  - Exactly 2 idle cycles between packets.
  - o_pkt_cnt=8 after 8 packets.
- Source 2 granted, sends nothing (TIMEOUT=64):
  - o_err_timeout pulses 64 cycles after the grant.
  - No write occurs.
  - Next grant goes to source 3.
- Source 1 sends 200 words with no last (AW=7):
  - Writes at addresses 0..127, with wlast at 127.
  - o_err_ovf pulses; words 128..199 are ignored.
- Source 0 stops after 5 words:
  - Dummy write at address 5 with wdata=0 and wlast=1.
  - o_err_timeout pulses; o_pkt_cnt is unchanged.
- rst_n=0 on word 30 of a packet:
  - All outputs are 0 the next cycle and the pointer is 0.
  - After release, a new request is served from address 0.
